// File: rtl/operand_loader.sv
// operand_loader: responder end of the loaddata/inputdata_ready four-phase
// handshake. While loaddata is high it collects two WIDTH-bit operands from
// an 8-bit valid/ready byte stream (little-endian, operand A first), then
// presents them atomically on opA/opB and raises inputdata_ready until
// loaddata falls.
// Optional stall timeout: compile with OPERAND_LOADER_TIMEOUT_EN defined.
module operand_loader #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loaddata,
  output logic             inputdata_ready,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic             timeout_err
);

  localparam int NBYTES = WIDTH / 8;
  localparam int NB2    = 2 * NBYTES;
  localparam int CW     = (NB2 > 1) ? $clog2(NB2) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB2 - 1);

  // Reject illegal parameterisations at elaboration time.
  if ((WIDTH < 8) || ((WIDTH % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("operand_loader: WIDTH must be a multiple of 8 (>= 8), TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   shadow_r;
  logic [2*WIDTH-1:0]   merged_s;
  logic [WIDTH-1:0]     opa_r, opb_r;
  logic                 timeout_err_r;
  logic                 accept_s;
  logic                 complete_s;
  logic                 timeout_s;

  // in_ready is decoded from state only, so accept never depends on a comb path.
  assign accept_s   = in_valid && (state_r == COLLECT);
  assign complete_s = accept_s && loaddata && (cnt_r == LAST);

`ifdef OPERAND_LOADER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_r;

  // Count consecutive COLLECT cycles without an accepted byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_r <= '0;
    end else if ((state_r != COLLECT) || accept_s) begin
      stall_r <= '0;
    end else begin
      stall_r <= stall_r + SW'(1);
    end
  end

  // Abort fires on the edge where the stall count would reach the limit;
  // a concurrent loaddata drop is an ordinary abort, not a timeout.
  assign timeout_s = (state_r == COLLECT) && loaddata && !accept_s &&
                     (stall_r == SW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state decode; abort by loaddata takes priority over completion.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (loaddata) state_s = COLLECT;
        else          state_s = IDLE;
      end
      COLLECT: begin
        if (!loaddata)      state_s = IDLE;
        else if (complete_s) state_s = ACK;
        else if (timeout_s)  state_s = IDLE;
        else                 state_s = COLLECT;
      end
      ACK: begin
        if (!loaddata) state_s = IDLE;
        else           state_s = ACK;
      end
      default: state_s = IDLE;
    endcase
  end

  // Shadow image with the byte being accepted merged into the final slot.
  always_comb begin
    merged_s = shadow_r;
    merged_s[(NB2-1)*8 +: 8] = in_data;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Byte index: held at zero outside COLLECT so every entry starts at byte 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (state_r != COLLECT) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Shadow byte capture at the current byte index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_r <= '0;
    end else begin
      for (int i = 0; i < NB2; i++) begin
        if (accept_s && (cnt_r == CW'(i))) shadow_r[i*8 +: 8] <= in_data;
      end
    end
  end

  // Operands update only on a completed collection, never with partial data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_r <= '0;
      opb_r <= '0;
    end else if (complete_s) begin
      opa_r <= merged_s[WIDTH-1:0];
      opb_r <= merged_s[2*WIDTH-1:WIDTH];
    end else begin
      opa_r <= opa_r;
      opb_r <= opb_r;
    end
  end

  // One-cycle timeout pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_err_r <= 1'b0;
    else        timeout_err_r <= timeout_s;
  end

  assign in_ready        = (state_r == COLLECT);
  assign inputdata_ready = (state_r == ACK);
  assign opA             = opa_r;
  assign opB             = opb_r;
  assign timeout_err     = timeout_err_r;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with WIDTH=16, TIMEOUT_CYCLES=10.
module tb_operand_loader;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             loaddata = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             inputdata_ready, in_ready, timeout_err;
  logic [WIDTH-1:0] opA, opB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_loader #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .loaddata(loaddata),
    .inputdata_ready(inputdata_ready), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .opA(opA), .opB(opB), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        ld;
    logic        v;
    logic [7:0]  d;
    logic        ack;
    logic        rdy;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic ld, logic v, logic [7:0] d, logic ack,
                              logic rdy, logic [15:0] a, logic [15:0] b);
    vec_t t;
    t.ld = ld; t.v = v; t.d = d; t.ack = ack; t.rdy = rdy; t.a = a; t.b = b;
    vecs.push_back(t);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(logic ld, logic v, logic [7:0] d);
    @(negedge clk);
    loaddata = ld; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ld v  d      ack rdy opA      opB
    add(0, 1, 8'hAA, 0, 0, 16'h0000, 16'h0000); // byte in IDLE ignored
    add(1, 0, 8'h00, 0, 1, 16'h0000, 16'h0000); // enter COLLECT
    add(1, 1, 8'h34, 0, 1, 16'h0000, 16'h0000);
    add(1, 1, 8'h12, 0, 1, 16'h0000, 16'h0000);
    add(1, 1, 8'h78, 0, 1, 16'h0000, 16'h0000);
    add(1, 1, 8'h56, 1, 0, 16'h1234, 16'h5678); // completion
    add(1, 1, 8'hFF, 1, 0, 16'h1234, 16'h5678); // byte in ACK ignored
    add(0, 0, 8'h00, 0, 0, 16'h1234, 16'h5678); // handshake release
    add(1, 0, 8'h00, 0, 1, 16'h1234, 16'h5678); // gapped transfer
    add(1, 1, 8'hBC, 0, 1, 16'h1234, 16'h5678);
    add(1, 0, 8'h00, 0, 1, 16'h1234, 16'h5678);
    add(1, 0, 8'h00, 0, 1, 16'h1234, 16'h5678);
    add(1, 1, 8'h9A, 0, 1, 16'h1234, 16'h5678);
    add(1, 0, 8'h00, 0, 1, 16'h1234, 16'h5678);
    add(1, 1, 8'hF0, 0, 1, 16'h1234, 16'h5678);
    add(1, 0, 8'h00, 0, 1, 16'h1234, 16'h5678);
    add(1, 1, 8'hDE, 1, 0, 16'h9ABC, 16'hDEF0);
    add(0, 0, 8'h00, 0, 0, 16'h9ABC, 16'hDEF0);
    add(1, 0, 8'h00, 0, 1, 16'h9ABC, 16'hDEF0); // abort after 2 bytes
    add(1, 1, 8'h11, 0, 1, 16'h9ABC, 16'hDEF0);
    add(1, 1, 8'h22, 0, 1, 16'h9ABC, 16'hDEF0);
    add(0, 0, 8'h00, 0, 0, 16'h9ABC, 16'hDEF0);
    add(1, 0, 8'h00, 0, 1, 16'h9ABC, 16'hDEF0); // restart from byte 0
    add(1, 1, 8'h01, 0, 1, 16'h9ABC, 16'hDEF0);
    add(1, 1, 8'h00, 0, 1, 16'h9ABC, 16'hDEF0);
    add(1, 1, 8'h02, 0, 1, 16'h9ABC, 16'hDEF0);
    add(1, 1, 8'h00, 1, 0, 16'h0001, 16'h0002);
    add(0, 0, 8'h00, 0, 0, 16'h0001, 16'h0002);

    // Power-on reset.
    #12;
    chk("por in_ready", in_ready, 0);
    chk("por ack", inputdata_ready, 0);
    chk("por opA", opA, 0);
    chk("por opB", opB, 0);
    chk("por timeout_err", timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d ack", i), inputdata_ready, vecs[i].ack);
      chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].rdy);
      chk($sformatf("vec%0d opA", i), opA, vecs[i].a);
      chk($sformatf("vec%0d opB", i), opB, vecs[i].b);
      chk($sformatf("vec%0d timeout_err", i), timeout_err, 0);
    end

    // Asynchronous reset in the middle of COLLECT.
    step(1, 0, 8'h00);
    step(1, 1, 8'h34);
    step(1, 1, 8'h12);
    #2;
    reset = 1'b0;
    #1;
    chk("arst in_ready", in_ready, 0);
    chk("arst ack", inputdata_ready, 0);
    chk("arst opA", opA, 0);
    chk("arst opB", opB, 0);
    chk("arst timeout_err", timeout_err, 0);
    @(negedge clk);
    loaddata = 1'b0; in_valid = 1'b0;
    reset = 1'b1;
    step(0, 0, 8'h00);
    chk("post-rst in_ready", in_ready, 0);
    step(1, 0, 8'h00);
    chk("post-rst collect", in_ready, 1);
    step(1, 1, 8'h34);
    step(1, 1, 8'h12);
    step(1, 1, 8'h78);
    step(1, 1, 8'h56);
    chk("post-rst ack", inputdata_ready, 1);
    chk("post-rst opA", opA, 16'h1234);
    chk("post-rst opB", opB, 16'h5678);
    step(0, 0, 8'h00);
    chk("post-rst release", inputdata_ready, 0);

    // Stall in COLLECT after one byte.
    step(1, 0, 8'h00);
    step(1, 1, 8'hAB);
`ifdef OPERAND_LOADER_TIMEOUT_EN
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 8'h00);
      chk($sformatf("stall%0d timeout_err", i), timeout_err, (i == 10));
      chk($sformatf("stall%0d in_ready", i), in_ready, (i != 10));
    end
    step(1, 0, 8'h00);
    chk("timeout pulse width", timeout_err, 0);
    chk("timeout re-collect", in_ready, 1);
    step(1, 1, 8'h11);
    step(1, 1, 8'h22);
    step(1, 1, 8'h33);
    step(1, 1, 8'h44);
    chk("timeout ack", inputdata_ready, 1);
    chk("timeout opA", opA, 16'h2211);
    chk("timeout opB", opB, 16'h4433);
`else
    for (int i = 1; i <= 15; i++) begin
      step(1, 0, 8'h00);
      chk($sformatf("stall%0d timeout_err", i), timeout_err, 0);
      chk($sformatf("stall%0d in_ready", i), in_ready, 1);
    end
    step(1, 1, 8'hCD);
    step(1, 1, 8'hEF);
    step(1, 1, 8'h01);
    chk("stall ack", inputdata_ready, 1);
    chk("stall opA", opA, 16'hCDAB);
    chk("stall opB", opB, 16'h01EF);
`endif
    step(0, 0, 8'h00);
    chk("final release", inputdata_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
# operand_loader

Responder end of the `loaddata`/`inputdata_ready` four-phase handshake driven by `controlunit`. When the control unit raises `loaddata`, this block collects two operands from an 8-bit valid/ready byte stream (switches/UART front end). It presents them to the multiplier datapath, then raises `inputdata_ready`. It drops `inputdata_ready` once `loaddata` falls.

## Interface
- `WIDTH`, default 8: operand width in bits; must be a multiple of 8 and ≥ 8. NBYTES = WIDTH/8.
- `TIMEOUT_CYCLES`, default 1000: stall limit in cycles; used only when the timeout feature is compiled in.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `loaddata` in 1: request from `controlunit`; high = collect a new operand pair.
- `inputdata_ready` out 1: acknowledge; high = `opA`/`opB` valid and stable.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: byte-stream data.
- `in_ready` out 1: byte-stream ready.
- `opA` out WIDTH: operand A.
- `opB` out WIDTH: operand B.
- `timeout_err` out 1: one-cycle pulse when collection is aborted on timeout.

## Operation
- States:
  - IDLE: reset state.
  - COLLECT
  - ACK
- Transitions:
  - IDLE -> COLLECT when `loaddata`=1.
  - COLLECT -> ACK at the edge that accepts the final byte (byte index 2*NBYTES-1).
  - COLLECT -> IDLE when `loaddata`=0; this is an abort and the partial data is discarded.
  - ACK -> IDLE when `loaddata`=0.
- Outputs by state:
  - `in_ready` = 1 only in COLLECT.
  - `inputdata_ready` = 1 only in ACK.
- Byte accept: at an edge with `in_valid`&&`in_ready`. `in_data` is written into shadow registers at byte index `cnt`, and `cnt` increments.
- Byte order: little-endian, A first.
  - Bytes 0..NBYTES-1 fill shadow A, LSB first.
  - Bytes NBYTES..2*NBYTES-1 fill shadow B, LSB first.
- `opA`/`opB` are loaded from the shadow registers, with the final byte merged in, at the COLLECT->ACK edge.
  - They never show partial values.
  - They hold until the next successful completion.
  - An abort or timeout leaves them unchanged.
- `cnt` width is clog2(2*NBYTES), with a minimum of 1 bit. `cnt` clears on entry to COLLECT.
- Asynchronous reset mid-operation: state returns to IDLE, and `cnt`, the shadow registers and all outputs clear immediately.
- Reset values: `inputdata_ready`=0, `in_ready`=0, `opA`=0, `opB`=0, `timeout_err`=0.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- `loaddata` rises at edge n-1 (sampled at edge n): `in_ready` is high after edge n.
- Final byte accepted at edge k: `inputdata_ready`=1, `in_ready`=0 and new `opA`/`opB` are visible after edge k.
- `loaddata` sampled low in ACK at edge m: `inputdata_ready`=0 after edge m.
- Minimum handshake: 1 + 2*NBYTES + 1 cycles with `in_valid` held high.
- If `loaddata` is still high after returning to IDLE (abort race or timeout), COLLECT is re-entered on the next edge with `cnt`=0.
- `in_valid` while not in COLLECT is ignored; no byte is consumed.

## Configuration
- `OPERAND_LOADER_TIMEOUT_EN` defined:
  - A stall counter clears on entry to COLLECT and on every accepted byte.
  - It increments on each COLLECT cycle with no accept.
  - When it reaches `TIMEOUT_CYCLES`, the block pulses `timeout_err` for one cycle, discards the partial data and goes to IDLE.
- Not defined:
  - COLLECT waits indefinitely.
  - `timeout_err` is tied to 0.
  - The stall counter is not synthesized.

## Test plan
- Reset: hold `reset`=0 mid-COLLECT -> all outputs 0 immediately. Release -> IDLE, `in_ready`=0.
- Nominal, WIDTH=16: `loaddata`=1, then bytes 0x34, 0x12, 0x78, 0x56 back-to-back -> `opA`=0x1234, `opB`=0x5678 and `inputdata_ready`=1 exactly 1 cycle after the 4th accept. Drop `loaddata` -> `inputdata_ready`=0 one cycle later.
- Gapped `in_valid` (random idle cycles between bytes) -> same operands. `opA`/`opB` keep their old values until the completion edge.
- Abort: drop `loaddata` after 2 of 4 bytes -> IDLE and `opA`/`opB` unchanged. Reassert `loaddata` and send 4 bytes 0x01, 0x00, 0x02, 0x00 -> `opA`=0x0001, `opB`=0x0002.
- Bytes presented in IDLE or ACK -> `in_ready`=0 and no state or operand change.
- With `OPERAND_LOADER_TIMEOUT_EN`, TIMEOUT_CYCLES=10: send 1 byte then stall -> `timeout_err` pulses once after 10 idle cycles, and the block restarts collection with `cnt`=0 while `loaddata` stays high.
